// File: rtl/click_sync_tx_pkg.sv
// Shared types and parameter bounds for the
// sync-to-click transmitter.
package click_pkg;

  typedef logic phase_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT_ACK
  } tx_state_t;

  localparam int CNT_W     = 4;
  localparam int SETUP_MIN = 1;
  localparam int SETUP_MAX = 15;
  localparam int SYNC_MIN  = 2;
  localparam int SYNC_MAX  = 4;

endpackage

// File: rtl/click_sync_tx_if.sv
// Producer handshake plus 2-phase click channel
// bundled into one interface.
interface click_sync_tx_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  out_req;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ack;
  logic                  busy;
  logic                  err;

  modport master (
    input  s_valid,
    input  s_data,
    input  out_ack,
    output s_ready,
    output out_req,
    output out_data,
    output busy,
    output err
  );

  modport slave (
    output s_valid,
    output s_data,
    output out_ack,
    input  s_ready,
    input  out_req,
    input  out_data,
    input  busy,
    input  err
  );

endinterface

// File: rtl/click_sync_tx_phase_sync.sv
// N-flop synchronizer for a 2-phase signal,
// async reset to a chosen phase.
module phase_sync
  import click_pkg::*;
#(
  parameter int     STAGES = 2,
  parameter phase_t INIT   = 1'b0
) (
  input  logic   clk,
  input  logic   reset,
  input  phase_t i_d,
  output phase_t o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the async phase through the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chain <= {STAGES{INIT}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/click_sync_tx.sv
// Clocked valid/ready to 2-phase bundled-data
// transmitter, one transaction outstanding.
module click_sync_tx
  import click_pkg::*;
#(
  parameter int     DATA_WIDTH     = 32,
  parameter phase_t PHASE_INIT_OUT = 1'b0,
  parameter int     SETUP_CYCLES   = 1,
  parameter int     SYNC_STAGES    = 2
) (
  input  logic           clk,
  input  logic           reset,
  click_sync_tx_if.master bus
);

  if (SETUP_CYCLES < SETUP_MIN ||
      SETUP_CYCLES > SETUP_MAX) begin : g_bad_setup
    $error("SETUP_CYCLES out of range");
  end
  if (SYNC_STAGES < SYNC_MIN ||
      SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $error("SYNC_STAGES out of range");
  end

  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(SETUP_CYCLES - 1);

  tx_state_t             r_state, w_next;
  logic [CNT_W-1:0]      r_cnt, w_cnt;
  logic                  r_ready, w_ready;
  phase_t                r_req, w_req;
  logic [DATA_WIDTH-1:0] r_data, w_data;
  logic                  r_err, w_err;
  phase_t                w_ack_s;

  phase_sync #(
    .STAGES (SYNC_STAGES),
    .INIT   (PHASE_INIT_OUT)
  ) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.out_ack),
    .o_q   (w_ack_s)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_req   <= PHASE_INIT_OUT;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_ready <= w_ready;
      r_req   <= w_req;
      r_data  <= w_data;
      r_err   <= w_err;
    end
  end

  // Next state; a phase mismatch outside
  // WAIT_ACK is a spurious ack and is only flagged.
  always_comb begin
    w_next  = r_state;
    w_cnt   = r_cnt;
    w_ready = r_ready;
    w_req   = r_req;
    w_data  = r_data;
    w_err   = r_err;
    unique case (r_state)
      IDLE: begin
        if (bus.s_valid && r_ready) begin
          w_data  = bus.s_data;
          w_cnt   = CNT_INIT;
          w_ready = 1'b0;
          w_next  = SETUP;
        end
      end
      SETUP: begin
        if (r_cnt == '0) begin
          w_req  = ~r_req;
          w_next = WAIT_ACK;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      WAIT_ACK: begin
        if (w_ack_s == r_req) begin
          w_next  = IDLE;
          w_ready = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
    if (r_state != WAIT_ACK && w_ack_s != r_req) begin
      w_err = 1'b1;
    end
  end

  assign bus.s_ready  = r_ready;
  assign bus.out_req  = r_req;
  assign bus.out_data = r_data;
  assign bus.busy     = (r_state != IDLE);
  assign bus.err      = r_err;

endmodule

// File: tb/tb_click_sync_tx.sv
// Directed plus randomized checks of
// click_sync_tx against a queue model.
module tb_click_sync_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  click_sync_tx_if #(.DATA_WIDTH(32)) a_if ();
  click_sync_tx_if #(.DATA_WIDTH(32)) b_if ();
  click_sync_tx_if #(.DATA_WIDTH(32)) c_if ();

  click_sync_tx u_a (
    .clk(clk), .reset(rst), .bus(a_if));
  click_sync_tx #(.SETUP_CYCLES(5)) u_b (
    .clk(clk), .reset(rst), .bus(b_if));
  click_sync_tx #(.PHASE_INIT_OUT(1'b1)) u_c (
    .clk(clk), .reset(rst), .bus(c_if));

  logic click_ack = 1'b0;
  logic spur = 1'b0;
  logic b_ack = 1'b0;
  logic c_ack = 1'b1;
  assign a_if.out_ack = click_ack ^ spur;
  assign b_if.out_ack = b_ack;
  assign c_if.out_ack = c_ack;

  logic [32:0] rxq[$];
  logic [32:0] expq[$];
  logic        exp_phase;

  int nchk = 0;
  int npass = 0;

  // Behavioural click stage: capture, ack 3 ns later.
  always @(a_if.out_req) begin
    if (!rst) rxq.push_back({a_if.out_req, a_if.out_data});
    #3 click_ack = a_if.out_req;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input string tag, input int which);
    int n;
    logic r;
    n = 0;
    r = 1'b0;
    while (n < 40 && !r) begin
      case (which)
        0: r = a_if.s_ready;
        1: r = b_if.s_ready;
        default: r = c_if.s_ready;
      endcase
      if (!r) step();
      n++;
    end
    chk(tag, 64'(r), 64'd1);
  endtask

  task automatic scen1(input string tag);
    a_if.s_valid = 1'b1;
    a_if.s_data  = 32'hDEADBEEF;
    step();
    chk({tag, "_data"}, 64'(a_if.out_data), 64'hDEADBEEF);
    chk({tag, "_rdy0"}, 64'(a_if.s_ready), 64'd0);
    chk({tag, "_busy"}, 64'(a_if.busy), 64'd1);
    chk({tag, "_req0"}, 64'(a_if.out_req), 64'(exp_phase));
    a_if.s_valid = 1'b0;
    step();
    exp_phase = ~exp_phase;
    expq.push_back({exp_phase, 32'hDEADBEEF});
    chk({tag, "_req1"}, 64'(a_if.out_req), 64'(exp_phase));
    step();
    chk({tag, "_rdyA"}, 64'(a_if.s_ready), 64'd0);
    step();
    chk({tag, "_rdyA1"}, 64'(a_if.s_ready), 64'd0);
    step();
    chk({tag, "_rdyA2"}, 64'(a_if.s_ready), 64'd1);
    chk({tag, "_idle"}, 64'(a_if.busy), 64'd0);
  endtask

  initial begin
    logic [31:0] w;
    int g;
    a_if.s_valid = 1'b0;
    a_if.s_data  = '0;
    b_if.s_valid = 1'b0;
    b_if.s_data  = '0;
    c_if.s_valid = 1'b0;
    c_if.s_data  = '0;
    exp_phase = 1'b0;
    #12;
    chk("rst_rdy", 64'(a_if.s_ready), 64'd1);
    chk("rst_req", 64'(a_if.out_req), 64'd0);
    chk("rst_data", 64'(a_if.out_data), 64'd0);
    chk("rst_err", 64'(a_if.err), 64'd0);
    chk("rst_busy", 64'(a_if.busy), 64'd0);
    chk("rst_c_req", 64'(c_if.out_req), 64'd1);
    step();
    rst = 1'b0;
    step();

    scen1("s1");

    w = $urandom;
    b_if.s_valid = 1'b1;
    b_if.s_data  = w;
    step();
    chk("b_data", 64'(b_if.out_data), 64'(w));
    b_if.s_valid = 1'b0;
    b_if.s_data  = ~w;
    for (int k = 1; k < 5; k++) begin
      step();
      chk("b_req_hold", 64'(b_if.out_req), 64'd0);
      chk("b_data_hold", 64'(b_if.out_data), 64'(w));
    end
    step();
    chk("b_req5", 64'(b_if.out_req), 64'd1);
    chk("b_data5", 64'(b_if.out_data), 64'(w));
    b_ack = 1'b1;
    wait_rdy("b_done", 1);
    chk("b_err", 64'(b_if.err), 64'd0);

    c_if.s_valid = 1'b1;
    c_if.s_data  = $urandom;
    step();
    c_if.s_valid = 1'b0;
    step();
    chk("c_req", 64'(c_if.out_req), 64'd0);
    c_ack = 1'b0;
    wait_rdy("c_done", 2);
    chk("c_err", 64'(c_if.err), 64'd0);

    for (int i = 0; i < 12; i++) begin
      w = (i < 4) ? 32'(i + 1) : $urandom;
      a_if.s_valid = 1'b1;
      a_if.s_data  = w;
      wait_rdy("st_rdy", 0);
      step();
      exp_phase = ~exp_phase;
      expq.push_back({exp_phase, w});
      chk("st_data", 64'(a_if.out_data), 64'(w));
      g = $urandom_range(0, 2);
      if (g != 0) begin
        a_if.s_valid = 1'b0;
        a_if.s_data  = $urandom;
        repeat (g) step();
        chk("st_hold", 64'(a_if.out_data), 64'(w));
      end
    end
    a_if.s_valid = 1'b0;
    wait_rdy("st_end", 0);
    chk("st_err", 64'(a_if.err), 64'd0);

    spur = 1'b1;
    repeat (4) step();
    chk("spur_err", 64'(a_if.err), 64'd1);
    spur = 1'b0;
    repeat (4) step();
    chk("spur_sticky", 64'(a_if.err), 64'd1);
    w = $urandom;
    a_if.s_valid = 1'b1;
    a_if.s_data  = w;
    step();
    a_if.s_valid = 1'b0;
    exp_phase = ~exp_phase;
    expq.push_back({exp_phase, w});
    wait_rdy("spur_next", 0);
    chk("spur_still", 64'(a_if.err), 64'd1);

    w = $urandom;
    a_if.s_valid = 1'b1;
    a_if.s_data  = w;
    step();
    a_if.s_valid = 1'b0;
    step();
    exp_phase = ~exp_phase;
    expq.push_back({exp_phase, w});
    chk("mid_busy", 64'(a_if.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("ar_rdy", 64'(a_if.s_ready), 64'd1);
    chk("ar_req", 64'(a_if.out_req), 64'd0);
    chk("ar_data", 64'(a_if.out_data), 64'd0);
    chk("ar_busy", 64'(a_if.busy), 64'd0);
    chk("ar_err", 64'(a_if.err), 64'd0);
    exp_phase = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    scen1("s5");

    chk("rx_count", 64'(rxq.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      if (i < rxq.size()) chk("rx_word", 64'(rxq[i]), 64'(expq[i]));
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
